// File: rtl/wimax_buf_pkg.sv
// rtl/wimax_buf_pkg.sv - shared constants and occupancy encoding for the ping-pong block buffer
package wimax_buf_pkg;

   // Entries per bank (one block) and offset width within a bank.
   localparam int BLOCK_LEN = 192;
   localparam int ADDR_W    = 8;

   // Number of banks holding a complete, unread block.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } occ_state_t;

endpackage

// File: rtl/block_addr_counter.sv
// rtl/block_addr_counter.sv - mod-LEN offset counter with enable and wrap pulse
module block_addr_counter
   import wimax_buf_pkg::*;
#(
   parameter int LEN = BLOCK_LEN,
   parameter int W   = ADDR_W
) (
   input  logic         clk,
   input  logic         resetN,
   input  logic         en_i,
   output logic [W-1:0] count_o,
   output logic         wrap_o
);

   // Terminal count sized to the counter so the compare never overflows.
   localparam logic [W-1:0] LAST = W'(LEN - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic         at_last;

   assign at_last = (count_q == LAST);

   // Wrap pulses only when the last position is actually consumed.
   assign wrap_o  = en_i && at_last;
   assign count_o = count_q;

   // Advance on enable, returning to zero after the last position.
   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = at_last ? '0 : (count_q + W'(1));
      end
   end

   // Offset register; reset discards any partial block.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pingpong_write_ctrl.sv
// rtl/pingpong_write_ctrl.sv - write-side controller for the two-bank ping-pong block buffer
module pingpong_write_ctrl
   import wimax_buf_pkg::*;
#(
   parameter int BLOCK_LEN = wimax_buf_pkg::BLOCK_LEN,
   parameter int ADDR_W    = wimax_buf_pkg::ADDR_W,
   parameter int DATA_W    = 1
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              ready_in,
   output logic [ADDR_W:0]   wraddress,
   output logic [DATA_W-1:0] wrdata,
   output logic              wren,
   output logic              valid_out,
   output logic              rd_bank,
   input  logic              read_done
);

   logic              accept;
   logic              blk_done;
   logic              rd_release;
   logic [ADDR_W-1:0] offset;

   logic              wr_bank_q;
   logic              wr_bank_d;
   logic              rd_bank_q;
   logic              rd_bank_d;

   occ_state_t        state_q;
   occ_state_t        state_d;

   // A sample is taken only on a completed handshake.
   assign accept     = valid_in && ready_in;

   // A release while nothing is pending is ignored entirely.
   assign rd_release = read_done && valid_out;

   block_addr_counter #(
      .LEN (BLOCK_LEN),
      .W   (ADDR_W)
   ) u_offset (
      .clk     (clk),
      .resetN  (resetN),
      .en_i    (accept),
      .count_o (offset),
      .wrap_o  (blk_done)
   );

   // Occupancy state register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Occupancy transitions; a fill and a release together cancel out.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (blk_done) state_d = HALF;
         end
         HALF: begin
            if (blk_done && !rd_release) begin
               state_d = FULL;
            end else if (rd_release && !blk_done) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // No fill can complete here because ready_in is low.
            if (rd_release) state_d = HALF;
         end
         default: state_d = EMPTY;
      endcase
   end

   // Flow-control outputs decoded straight from the occupancy state.
   always_comb begin
      ready_in  = (state_q != FULL);
      valid_out = (state_q != EMPTY);
   end

   // Bank pointers: writer flips on block complete, reader on an honoured release.
   always_comb begin
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      if (blk_done)   wr_bank_d = ~wr_bank_q;
      if (rd_release) rd_bank_d = ~rd_bank_q;
   end

   // Bank pointer registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
      end else begin
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
      end
   end

   // RAM write port is combinational from the handshake; the address is
   // always visible even when no write is strobed.
   always_comb begin
      wren      = accept;
      wraddress = {wr_bank_q, offset};
      wrdata    = data_in;
      rd_bank   = rd_bank_q;
   end

endmodule

// File: tb/tb_pingpong_write_ctrl.sv
// tb/tb_pingpong_write_ctrl.sv - self-checking bench for pingpong_write_ctrl
module tb_pingpong_write_ctrl;

   localparam int BL = 192;

   logic       clk = 1'b0;
   logic       resetN;
   logic       valid_in;
   logic [0:0] data_in;
   logic       ready_in;
   logic [8:0] wraddress;
   logic [0:0] wrdata;
   logic       wren;
   logic       valid_out;
   logic       rd_bank;
   logic       read_done;

   always #5 clk = ~clk;

   pingpong_write_ctrl dut (
      .clk       (clk),
      .resetN    (resetN),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .ready_in  (ready_in),
      .wraddress (wraddress),
      .wrdata    (wrdata),
      .wren      (wren),
      .valid_out (valid_out),
      .rd_bank   (rd_bank),
      .read_done (read_done)
   );

   typedef struct {
      logic       v;
      logic       d;
      logic       rd;
      logic       e_ready;
      logic       e_wren;
      logic [8:0] e_addr;
      logic       e_wrdata;
      logic       e_vo;
      logic       e_rb;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[8];

   int   n_cmp = 0;
   int   n_bad = 0;

   int   m_off;
   int   m_cnt;
   logic m_wb;
   logic m_rb;

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, d, rd, r, w, input logic [8:0] a,
                               input logic wd, vo, rb);
      vec_t e;
      e.v = v; e.d = d; e.rd = rd;
      e.e_ready = r; e.e_wren = w; e.e_addr = a;
      e.e_wrdata = wd; e.e_vo = vo; e.e_rb = rb;
      return e;
   endfunction

   function automatic vec_t model_vec(input logic v, d, rd);
      logic rdy;
      rdy = (m_cnt != 2);
      return mk(v, d, rd, rdy, v && rdy, {m_wb, 8'(m_off)}, d, m_cnt != 0, m_rb);
   endfunction

   task automatic model_update(input logic v, rd);
      logic acc, blk, rel;
      acc = v && (m_cnt != 2);
      blk = acc && (m_off == BL - 1);
      rel = rd && (m_cnt != 0);
      if (acc) m_off = blk ? 0 : m_off + 1;
      if (blk) m_wb = ~m_wb;
      if (rel) m_rb = ~m_rb;
      m_cnt = m_cnt + (blk ? 1 : 0) - (rel ? 1 : 0);
   endtask

   task automatic apply(input vec_t e, input string tag);
      vec_t got;
      valid_in  = e.v;
      data_in   = e.d;
      read_done = e.rd;
      exp_q.push_back(e);
      @(negedge clk);
      got = exp_q.pop_front();
      check({tag, ".ready_in"},  ready_in,  got.e_ready);
      check({tag, ".wren"},      wren,      got.e_wren);
      check({tag, ".wraddress"}, wraddress, got.e_addr);
      check({tag, ".wrdata"},    wrdata,    got.e_wrdata);
      check({tag, ".valid_out"}, valid_out, got.e_vo);
      check({tag, ".rd_bank"},   rd_bank,   got.e_rb);
      model_update(e.v, e.rd);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic v, d, rd, input string tag);
      apply(model_vec(v, d, rd), tag);
   endtask

   task automatic fill(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b1, 1'($urandom), 1'b0, tag);
   endtask

   // Asynchronous reset mid-cycle; outputs must drop without waiting for a clock.
   task automatic do_reset(input string tag);
      valid_in  = 1'b0;
      read_done = 1'b0;
      data_in   = 1'b0;
      #2;
      resetN = 1'b0;
      #1;
      check({tag, ".rst_ready_in"},  ready_in,  9'h1);
      check({tag, ".rst_valid_out"}, valid_out, 9'h0);
      check({tag, ".rst_wren"},      wren,      9'h0);
      check({tag, ".rst_wraddress"}, wraddress, 9'h000);
      check({tag, ".rst_rd_bank"},   rd_bank,   9'h0);
      m_off = 0; m_cnt = 0; m_wb = 1'b0; m_rb = 1'b0;
      @(negedge clk);
      resetN = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetN    = 1'b0;
      valid_in  = 1'b0;
      data_in   = 1'b0;
      read_done = 1'b0;
      //            v  d  rd rdy wren addr    wd vo rb
      tbl[0] = mk(0, 0, 0, 1,  0,   9'h000, 0, 0, 0);
      tbl[1] = mk(1, 1, 0, 1,  1,   9'h000, 1, 0, 0);
      tbl[2] = mk(1, 0, 0, 1,  1,   9'h001, 0, 0, 0);
      tbl[3] = mk(0, 1, 1, 1,  0,   9'h002, 1, 0, 0);
      tbl[4] = mk(0, 0, 0, 1,  0,   9'h002, 0, 0, 0);
      tbl[5] = mk(1, 1, 1, 1,  1,   9'h002, 1, 0, 0);
      tbl[6] = mk(1, 0, 0, 1,  1,   9'h003, 0, 0, 0);
      tbl[7] = mk(0, 0, 0, 1,  0,   9'h004, 0, 0, 0);
      @(posedge clk);
      #1;

      do_reset("init");
      for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("tbl%0d", i));

      // One full block, then the second block fills the buffer.
      do_reset("blk");
      fill(BL, "fill_a");
      check("blk1.valid_out", valid_out, 9'h1);
      check("blk1.rd_bank",   rd_bank,   9'h0);
      check("blk1.wraddress", wraddress, 9'h100);
      fill(BL, "fill_b");
      check("full.ready_in", ready_in, 9'h0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0, "blocked");
      check("full.held_addr", wraddress, 9'h000);
      step(1'b0, 1'b0, 1'b1, "rd_a");
      check("rel.ready_in",  ready_in,  9'h1);
      check("rel.rd_bank",   rd_bank,   9'h1);
      check("rel.wraddress", wraddress, 9'h000);
      step(1'b1, 1'b1, 1'b0, "resume");

      // Refill to FULL, then back-to-back releases drain both banks.
      fill(BL - 1, "refill");
      check("refull.ready_in", ready_in, 9'h0);
      step(1'b0, 1'b0, 1'b1, "rd_x1");
      step(1'b0, 1'b0, 1'b1, "rd_x2");
      check("drain.valid_out", valid_out, 9'h0);
      check("drain.rd_bank",   rd_bank,   9'h1);
      step(1'b0, 1'b0, 1'b1, "rd_empty");
      check("rd_empty.rd_bank", rd_bank, 9'h1);

      // Block complete into B in the same cycle as the release of A.
      do_reset("same");
      fill(BL, "same_a");
      fill(BL - 1, "same_b");
      step(1'b1, 1'($urandom), 1'b1, "same_cycle");
      check("same.valid_out", valid_out, 9'h1);
      check("same.ready_in",  ready_in,  9'h1);
      check("same.rd_bank",   rd_bank,   9'h1);
      check("same.wraddress", wraddress, 9'h000);

      // Gapped source: completion counts accepted samples, not cycles.
      do_reset("gap");
      for (int i = 0; i < 2 * (BL - 1); i++)
         step(i[0] == 1'b0, 1'($urandom), 1'b0, "gap");
      check("gap191.valid_out", valid_out, 9'h0);
      check("gap191.wraddress", wraddress, 9'h0BF);
      step(1'b1, 1'b1, 1'b0, "gap_last");
      check("gap192.valid_out", valid_out, 9'h1);
      check("gap192.wraddress", wraddress, 9'h100);

      // Reset with one bank full and the other part-written.
      do_reset("mid");
      fill(BL, "mid_a");
      fill(100, "mid_b");
      check("mid.wraddress", wraddress, 9'h164);
      check("mid.valid_out", valid_out, 9'h1);
      do_reset("mid_rst");
      step(1'b1, 1'b1, 1'b0, "post_rst");
      check("post_rst.wraddress", wraddress, 9'h001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
